// File: rtl/data_mem_controller_pkg.sv
// Shared types for the data-memory controller.
// Contents:
//   mem_load_func3_t  : RV32 load func3 encodings (LB/LH/LW/LBU/LHU)
//   mem_store_func3_t : RV32 store func3 encodings (SB/SH/SW)
//   dmem_state_t      : controller FSM states (IDLE/BUSY/RESP)
package definitions;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_load_func3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } mem_store_func3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_mem_controller_if.sv
// MEM-stage <-> data-memory request/response bundle.
// master (MEM stage) drives: memRead, memWrite, func3, addr, wdata
// slave  (controller) drives: rdata, ready, misalign
interface data_mem_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  memRead;
  logic                  memWrite;
  logic [2:0]            func3;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  misalign;

  modport master (
    output memRead, memWrite, func3, addr, wdata,
    input  rdata, ready, misalign
  );

  modport slave (
    input  memRead, memWrite, func3, addr, wdata,
    output rdata, ready, misalign
  );
endinterface

// File: rtl/data_mem_controller_load_store_align.sv
// Combinational byte-lane steering for the data-memory controller.
// Inputs : func3, is_store, addr_lo (addr[1:0]), wdata, raw_word (addressed word)
// Outputs: byte_en (store lane enables), wr_word (lane-replicated store data),
//          load_data (sign/zero-extended load result), misalign
// Macro DMEM_MISALIGN_TRAP_EN enables misaligned detection; otherwise
// misalign is 0 and the low address bits below the access size are ignored.
module load_store_align
  import definitions::*;
(
  input  logic [2:0]  func3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic        acc_byte;
  logic        acc_half;
  logic        sign_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Size decode differs for loads and stores: store func3 100/101 are words.
  always_comb begin
    acc_byte  = 1'b0;
    acc_half  = 1'b0;
    sign_ext  = ~func3[2];
    byte_en   = 4'b0000;
    wr_word   = '0;
    load_data = '0;
    misalign  = 1'b0;
    byte_v    = '0;

    if (is_store) begin
      acc_byte = (func3 == SB);
      acc_half = (func3 == SH);
    end else begin
      acc_byte = (func3 == LB) || (func3 == LBU);
      acc_half = (func3 == LH) || (func3 == LHU);
    end

    case (addr_lo)
      2'd0:    byte_v = raw_word[7:0];
      2'd1:    byte_v = raw_word[15:8];
      2'd2:    byte_v = raw_word[23:16];
      default: byte_v = raw_word[31:24];
    endcase
    half_v = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    if (acc_byte) begin
      byte_en   = 4'b0001 << addr_lo;
      wr_word   = {4{wdata[7:0]}};
      load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
    end else if (acc_half) begin
      byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
      wr_word   = {2{wdata[15:0]}};
      load_data = {{16{sign_ext & half_v[15]}}, half_v};
    end else begin
      byte_en   = 4'b1111;
      wr_word   = wdata;
      load_data = raw_word;
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (acc_half & addr_lo[0]) |
               (~acc_byte & ~acc_half & (addr_lo != 2'b00));
`endif
  end

endmodule

// File: rtl/data_mem_controller.sv
// Data-memory responder: accepts MEM-stage loads/stores, performs
// byte/half/word accesses on an internal word array after LATENCY cycles and
// answers with a one-cycle ready pulse plus extended load data.
// Ports: clk, rst (sync, active-high), bus (data_mem_controller_if.slave).
// Macro DMEM_MISALIGN_TRAP_EN: flag misaligned accesses, suppress their
// store and return rdata = 0; otherwise misalign is tied to 0.
module data_mem_controller
  import definitions::*;
#(
  parameter int unsigned DM_MEM_DEPTH = 4096,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LATENCY      = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_controller_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DM_MEM_DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = DATA_WIDTH / 8;

  dmem_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic                  misalign_q;
`endif

  logic [DATA_WIDTH-1:0] mem [DM_MEM_DEPTH];

  logic                  in_idle_c;
  logic                  req_c;
  logic                  go_resp_c;
  logic                  cur_rd_c;
  logic                  cur_wr_c;
  logic [2:0]            cur_func3_c;
  logic [DATA_WIDTH-1:0] cur_addr_c;
  logic [DATA_WIDTH-1:0] cur_wdata_c;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] raw_c;
  logic [LANES-1:0]      be_c;
  logic [DATA_WIDTH-1:0] wr_word_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic                  mis_c;
  logic                  wr_en_c;
  logic                  unused_addr;

  // With LATENCY = 1 the access completes straight from IDLE, so the
  // datapath uses the live request there and the latched copy otherwise.
  always_comb begin
    in_idle_c   = (state_q == IDLE);
    req_c       = bus.memRead | bus.memWrite;
    cur_rd_c    = in_idle_c ? bus.memRead  : rd_q;
    cur_wr_c    = in_idle_c ? bus.memWrite : wr_q;
    cur_func3_c = in_idle_c ? bus.func3    : func3_q;
    cur_addr_c  = in_idle_c ? bus.addr     : addr_q;
    cur_wdata_c = in_idle_c ? bus.wdata    : wdata_q;
    go_resp_c   = (in_idle_c && req_c && (LATENCY == 1)) ||
                  ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
    idx_c       = cur_addr_c[2 +: IDX_W];
    raw_c       = mem[idx_c];
    wr_en_c     = go_resp_c && cur_wr_c && !mis_c && !rst;
  end

  // Upper address bits wrap by design.
  assign unused_addr = ^cur_addr_c[DATA_WIDTH-1:2+IDX_W];

  load_store_align u_align (
    .func3     (cur_func3_c),
    .is_store  (cur_wr_c),
    .addr_lo   (cur_addr_c[1:0]),
    .wdata     (cur_wdata_c),
    .raw_word  (raw_c),
    .byte_en   (be_c),
    .wr_word   (wr_word_c),
    .load_data (load_c),
    .misalign  (mis_c)
  );

  // Store commit on the edge entering RESP; array is never reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wr_word_c[8*i +: 8];
      end
    end
  end

  // Controller FSM; ready/rdata/misalign are registered on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      func3_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      ready_q <= go_resp_c;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= go_resp_c && mis_c;
`endif
      // Read+write together behaves as a store that returns zero.
      if (go_resp_c && cur_rd_c) rdata_q <= (cur_wr_c || mis_c) ? '0 : load_c;

      case (state_q)
        IDLE: begin
          if (req_c) begin
            func3_q <= bus.func3;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rd_q    <= bus.memRead;
            wr_q    <= bus.memWrite;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign bus.misalign = misalign_q;
`else
  assign bus.misalign = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller (LATENCY = 2). Expected load
// results are queued at issue and compared when ready pulses.
// Honors DMEM_MISALIGN_TRAP_EN for the misaligned-load cases.
module tb_data_mem_controller;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic        mis;
  } sb_item_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   ready_count;
  sb_item_t sb_q[$];
  sb_item_t mon_item;

  data_mem_controller_if #(.DATA_WIDTH(32)) bus ();

  data_mem_controller #(
    .DM_MEM_DEPTH (4096),
    .DATA_WIDTH   (32),
    .LATENCY      (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pop and compare on every ready pulse.
  always @(negedge clk) begin
    if (!rst && bus.ready) begin
      ready_count++;
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_item = sb_q.pop_front();
        if (mon_item.is_load) check("rdata", bus.rdata, mon_item.rdata);
        check("misalign", 32'(bus.misalign), 32'(mon_item.mis));
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.memRead  = rd;
    bus.memWrite = wr;
    bus.func3    = f3;
    bus.addr     = a;
    bus.wdata    = wd;
  endtask

  // One access issued from IDLE, held until ready, latency checked.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis);
    sb_item_t it;
    int  lat;
    logic seen;
    @(posedge clk); #1;
    drive(rd, wr, f3, a, wd);
    it.is_load = rd;
    it.rdata   = exp_rd;
    it.mis     = exp_mis;
    sb_q.push_back(it);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    if (seen) check("latency", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    access(1'b0, 1'b1, f3, a, wd, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_mis);
    access(1'b1, 1'b0, f3, a, 32'h0, exp_rd, exp_mis);
  endtask

  initial begin
    int       first_r;
    int       second_r;
    int       rc0;
    int       hits;
    sb_item_t it;

    n_checks    = 0;
    n_fail      = 0;
    ready_count = 0;
    rst         = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_misalign", 32'(bus.misalign), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word store / load
    store(3'b010, 32'h10, 32'hDEADBEEF);
    load(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

    // Back-to-back loads with memRead held across ready
    @(posedge clk); #1;
    rc0 = ready_count;
    it.is_load = 1'b1; it.rdata = 32'hDEADBEEF; it.mis = 1'b0;
    sb_q.push_back(it);
    sb_q.push_back(it);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    first_r  = -1;
    second_r = -1;
    hits     = 0;
    for (int i = 0; i < 20 && hits < 2; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        if (hits == 0) first_r = i;
        else second_r = i;
        hits++;
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("b2b_first", 32'(first_r), 32'(LAT));
    check("b2b_second", 32'(second_r), 32'(2 * LAT + 1));
    repeat (6) @(posedge clk);
    #1;
    check("b2b_pulses", 32'(ready_count - rc0), 32'd2);

    // Byte store into a known word, then byte loads
    store(3'b010, 32'h10, 32'h11223344);
    store(3'b000, 32'h13, 32'h000000A5);
    load(3'b010, 32'h10, 32'hA5223344, 1'b0);
    load(3'b000, 32'h13, 32'hFFFFFFA5, 1'b0);
    load(3'b100, 32'h13, 32'h000000A5, 1'b0);
    load(3'b000, 32'h11, 32'h00000033, 1'b0);

    // Half store / loads
    store(3'b010, 32'h20, 32'h00000000);
    store(3'b001, 32'h22, 32'h00008001);
    load(3'b001, 32'h22, 32'hFFFF8001, 1'b0);
    load(3'b101, 32'h22, 32'h00008001, 1'b0);
    load(3'b010, 32'h20, 32'h80010000, 1'b0);

    // Read and write together: store wins, rdata forced to zero
    access(1'b1, 1'b1, 3'b010, 32'h30, 32'h12345678, 32'h0, 1'b0);
    load(3'b010, 32'h30, 32'h12345678, 1'b0);

    // Non-standard func3 codes act as word accesses
    store(3'b100, 32'h50, 32'hA1B2C3D4);
    load(3'b111, 32'h50, 32'hA1B2C3D4, 1'b0);
    load(3'b011, 32'h50, 32'hA1B2C3D4, 1'b0);

    // Reset during BUSY aborts the store
    store(3'b010, 32'h40, 32'h11111111);
    rc0 = ready_count;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h00000055);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", 32'(ready_count - rc0), 32'd0);
    check("midrst_rdata", bus.rdata, 32'h0);
    load(3'b010, 32'h40, 32'h11111111, 1'b0);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    load(3'b010, 32'h41, 32'h00000000, 1'b1);
    load(3'b001, 32'h23, 32'h00000000, 1'b1);
    access(1'b0, 1'b1, 3'b010, 32'h42, 32'hFFFFFFFF, 32'h0, 1'b1);
    load(3'b010, 32'h40, 32'h11111111, 1'b0);
`else
    load(3'b010, 32'h41, 32'h11111111, 1'b0);
    load(3'b001, 32'h23, 32'hFFFF8001, 1'b0);
    store(3'b010, 32'h42, 32'h87654321);
    load(3'b010, 32'h40, 32'h87654321, 1'b0);
`endif

    // Address wrap beyond the array depth
    store(3'b010, 32'h10 + 32'(4 * 4096), 32'hCAFEF00D);
    load(3'b010, 32'h10, 32'hCAFEF00D, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
# data_mem_controller

Responder side of the processor's data-memory port: accepts load/store requests from the MEM stage (memRead/memWrite, func3, address, store data), performs byte/half/word accesses on an internal word-organised array, and answers with a one-cycle `ready` pulse plus sign/zero-extended load data. It sits between the pipeline's MEM stage and the data RAM. The hazard unit stalls on `ready`, and the MEM/WB register captures `rdata` on `ready`.

## Interface
Parameters:
- `DM_MEM_DEPTH`, 4096: number of 32-bit words in the array.
- `DATA_WIDTH`, 32: data and address width.
- `LATENCY`, 2: cycles from request acceptance to `ready`. Legal values are 1 to 15.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `memRead`, input, 1: load request, held until `ready`.
- `memWrite`, input, 1: store request, held until `ready`.
- `func3`, input, 3: access size and sign (RV32 load/store func3).
- `addr`, input, DATA_WIDTH: byte address (ALU output).
- `wdata`, input, DATA_WIDTH: store data (rs2 value).
- `rdata`, output, DATA_WIDTH: extended load data.
- `ready`, output, 1: completion pulse, one cycle wide.
- `misalign`, output, 1: misaligned-access flag. Tied to 0 unless the feature below is compiled in.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE: if `memRead | memWrite`, latch `func3`, `addr` and `wdata`, load the counter with LATENCY-1, then:
  - go to RESP if LATENCY = 1;
  - go to BUSY otherwise.
- BUSY: decrement the counter each cycle. At 1, go to RESP.
- RESP:
  - assert `ready`;
  - commit the store, or update `rdata`;
  - return to IDLE.
- Request inputs are not re-sampled in RESP. A request still high in the following IDLE cycle is a new request, which makes back-to-back memory instructions work.
- `memRead` and `memWrite` both high: treated as a store; `rdata` is set to 0.
- Word index = `addr[2+:$clog2(DM_MEM_DEPTH)]`. Upper address bits are ignored, so out-of-range addresses wrap.
- Loads:
  - func3 000 (LB): byte at `addr[1:0]`, sign-extended.
  - func3 100 (LBU): byte at `addr[1:0]`, zero-extended.
  - func3 001 (LH): half at `addr[1]`, sign-extended.
  - func3 101 (LHU): half at `addr[1]`, zero-extended.
  - func3 010 (LW): full word.
  - func3 011, 110, 111: treated as LW.
- Stores:
  - func3 000 (SB): `wdata[7:0]` to the byte lane selected by `addr[1:0]`.
  - func3 001 (SH): `wdata[15:0]` to the half selected by `addr[1]`.
  - func3 010 and others: full word.
  - Only the enabled byte lanes change.
- Array contents are not reset and are uninitialised.

## Timing
- Request seen in IDLE at cycle 0 → `ready` high during cycle LATENCY → next request can be accepted at cycle LATENCY+1.
- Throughput is one access per LATENCY+1 cycles.
- `rdata` is registered, valid during the `ready` cycle, and held until the next load completes.
- Store data is visible to a load accepted in any later IDLE cycle (read-after-write is ordered).
- Reset values: `ready` = 0, `rdata` = 0, `misalign` = 0, state = IDLE, counter = 0.
- Reset mid-operation: the transaction is aborted, no write is committed, and no `ready` is issued.
- Request dropped while BUSY: this is illegal and not checked. The latched request completes regardless.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are LH/LHU/SH with `addr[0]` = 1, and LW/SW with `addr[1:0]` ≠ 0.
  - They still complete with `ready` at normal latency.
  - `misalign` pulses with `ready`, the store is suppressed, and `rdata` = 0.
- Not defined:
  - `misalign` is constant 0.
  - Low address bits below the access size are ignored (the address is forced to alignment).

## Structure
- Shared package `definitions`:
  - `mem_func3_t` enum: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010. Use separate load and store enums if the names collide.
  - `dmem_state_t` (IDLE/BUSY/RESP).
- Sub-module `load_store_align` (combinational):
  - inputs: func3, `addr[1:0]`, wdata, raw word;
  - outputs: 4-bit byte enable, lane-shifted write word, extended load data, misaligned flag.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (LATENCY=2) → `ready` at cycles 2 and 5 from the first request, `rdata` = 0xDEADBEEF.
- SB 0x13 data 0x000000A5 over a word of 0x11223344, then LW 0x10 → 0xA5223344. Then LB 0x13 → 0xFFFFFFA5, and LBU 0x13 → 0x000000A5.
- SH 0x22 data 0x8001 over a word of 0, then LH 0x22 → 0xFFFF8001, and LHU 0x22 → 0x00008001.
- Back-to-back loads with `memRead` held high across `ready` → exactly two `ready` pulses, one idle cycle between them.
- `rst` asserted in BUSY during SW 0x40 data 0x55 → no `ready`, and a later LW 0x40 returns the prior contents.
- With `DMEM_MISALIGN_TRAP_EN`: LW 0x41 → `ready` and `misalign` both high, `rdata` = 0. Without it: LW 0x41 returns the word at 0x40.
